// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with 16x-oversampled bit timing.
// Sends one frame per accepted request: a start bit, 8 data bits LSB first,
// an optional parity bit, then 1 or 2 stop bits. Each bit lasts 16 b_ticks.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   b_tick   baud x16 tick, one clk wide
//   tx_start request to send tx_data; ignored while tx_busy is high
//   tx_data  byte to send; captured only when tx_start is accepted
//   tx       serial line, idle high (registered)
//   tx_busy  high from acceptance until the end of the frame (registered)
//   tx_done  one-clk pulse at the end of the frame (registered)
module uart_tx #(
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic       HAS_PARITY = (PARITY_EN != 0);
  localparam logic       ODD_INIT   = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state, state_n;
  logic [3:0] tick_cnt, tick_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n;
  logic       tx_n, busy_n, done_n;
  logic       bit_end;

  assign bit_end = b_tick && (tick_cnt == 4'd15);

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    busy_n     = tx_busy;
    done_n     = 1'b0;

    if (state != IDLE && b_tick) begin
      tick_cnt_n = tick_cnt + 4'd1;
    end

    unique case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_n    = tx_data;
          par_n      = (^tx_data) ^ ODD_INIT;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          busy_n     = 1'b1;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = HAS_PARITY ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          // bit_cnt counts completed stop bits here (it is 0 on entry).
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is decoded from the next state so tx stays a plain register
    // yet changes on the same edge as the state.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// Four instances cover the default 8N1 build, even and odd parity, and two
// stop bits. A small 16x-oversampling receiver listens to the default
// instance for the loopback scenario.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       b_tick;
  logic       start [4];
  logic [7:0] data  [4];
  logic       tx_w  [4];
  logic       busy_w[4];
  logic       done_w[4];

  int checks;
  int errors;

  logic [7:0] rx_q[$];
  int         rx_err;

  uart_tx u0 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_start(start[0]), .tx_data(data[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_start(start[1]), .tx_data(data[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_start(start[2]), .tx_data(data[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );
  uart_tx #(.STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .b_tick(b_tick), .tx_start(start[3]), .tx_data(data[3]),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // b_tick: one clk high out of every four, changed on the falling edge.
  initial begin
    b_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic rx_wait(input int n);
    repeat (n) begin
      do @(posedge clk); while (!b_tick);
      @(negedge clk);
    end
  endtask

  // Reference 8N1 receiver on instance 0: sample at mid-bit, 16 ticks apart.
  initial begin
    logic [7:0] rb;
    rx_err = 0;
    forever begin
      @(negedge clk);
      if (tx_w[0] === 1'b0) begin
        rx_wait(8);
        if (tx_w[0] !== 1'b0) begin
          rx_err++;
        end else begin
          for (int b = 0; b < 8; b++) begin
            rx_wait(16);
            rb[b] = tx_w[0];
          end
          rx_wait(16);
          if (tx_w[0] !== 1'b1) rx_err++;
          else rx_q.push_back(rb);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!b_tick);
      @(negedge clk);
    end
  endtask

  // Sends one frame on instance idx and records mid-bit samples of tx,
  // b_ticks until tx_done, clks with tx_busy high and tx_done pulses.
  // With chain set, tx_start is raised in the tx_done clk for chain_d.
  // With poke_tc > 0, tx_start is pulsed with 0x3C at that tick count.
  task automatic run_frame(input int idx, input logic [7:0] d, input bit pulse,
                           input bit chain, input logic [7:0] chain_d, input int poke_tc,
                           output logic [15:0] bits, output int tc, output int busy_clks,
                           output int done_cnt, output logic tx_first, output logic busy_first);
    int  nb;
    bit  poked;
    bit  t;
    bits = '0; tc = 0; done_cnt = 0; nb = 0; poked = 0;
    if (pulse) begin
      @(negedge clk);
      start[idx] = 1'b1;
      data[idx]  = d;
    end
    @(posedge clk);
    @(negedge clk);
    start[idx] = 1'b0;
    data[idx]  = ~d;
    tx_first   = tx_w[idx];
    busy_first = busy_w[idx];
    busy_clks  = busy_w[idx] ? 1 : 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      t = b_tick;
      @(negedge clk);
      start[idx] = 1'b0;
      if (t) begin
        tc++;
        if (tc % 16 == 8 && nb < 16) begin
          bits[nb] = tx_w[idx];
          nb++;
        end
      end
      if (busy_w[idx]) busy_clks++;
      if (done_w[idx]) begin
        done_cnt++;
        if (chain) begin
          start[idx] = 1'b1;
          data[idx]  = chain_d;
        end
        break;
      end
      if (poke_tc > 0 && tc == poke_tc && !poked) begin
        start[idx] = 1'b1;
        data[idx]  = 8'h3C;
        poked      = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    checks++; if (tx_w[0] !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_w[0]); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (tx_w[3] !== 1'b1) begin errors++; $display("FAIL idle_tx got %b exp 1", tx_w[3]); end
    checks++; if (busy_w[3] !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy_w[3]); end
  endtask

  task automatic test_basic;
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    run_frame(0, 8'h55, 1, 0, 8'h00, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (txf !== 1'b0) begin errors++; $display("FAIL basic_latency_tx got %b exp 0", txf); end
    checks++; if (bf !== 1'b1) begin errors++; $display("FAIL basic_latency_busy got %b exp 1", bf); end
    checks++; if (bits !== 16'h02AA) begin errors++; $display("FAIL basic_bits got %h exp 02aa", bits); end
    checks++; if (tc !== 160) begin errors++; $display("FAIL basic_ticks got %0d exp 160", tc); end
    checks++; if (bc < 636 || bc > 644) begin errors++; $display("FAIL basic_busy_clks got %0d exp 636..644", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", dc); end
    @(negedge clk);
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done_w[0]); end
    checks++; if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++; $display("FAIL basic_idle got tx=%b busy=%b exp tx=1 busy=0", tx_w[0], busy_w[0]);
    end
  endtask

  task automatic test_parity;
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    run_frame(1, 8'hA5, 1, 0, 8'h00, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (bits !== 16'h054A) begin errors++; $display("FAIL parity_even_bits got %h exp 054a", bits); end
    checks++; if (tc !== 176) begin errors++; $display("FAIL parity_even_ticks got %0d exp 176", tc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL parity_even_done got %0d exp 1", dc); end
    run_frame(2, 8'hA5, 1, 0, 8'h00, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (bits !== 16'h074A) begin errors++; $display("FAIL parity_odd_bits got %h exp 074a", bits); end
    checks++; if (tc !== 176) begin errors++; $display("FAIL parity_odd_ticks got %0d exp 176", tc); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    run_frame(3, 8'h00, 1, 1, 8'hFF, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (bits !== 16'h0600) begin errors++; $display("FAIL b2b_first_bits got %h exp 0600", bits); end
    checks++; if (tc !== 176) begin errors++; $display("FAIL b2b_first_ticks got %0d exp 176", tc); end
    run_frame(3, 8'hFF, 0, 0, 8'h00, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (txf !== 1'b0 || bf !== 1'b1) begin
      errors++; $display("FAIL b2b_no_gap got tx=%b busy=%b exp tx=0 busy=1", txf, bf);
    end
    checks++; if (bits !== 16'h07FE) begin errors++; $display("FAIL b2b_second_bits got %h exp 07fe", bits); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL b2b_second_done got %0d exp 1", dc); end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    int extra;
    run_frame(0, 8'h96, 1, 0, 8'h00, 40, bits, tc, bc, dc, txf, bf);
    checks++; if (bits !== 16'h032C) begin errors++; $display("FAIL ignore_bits got %h exp 032c", bits); end
    checks++; if (tc !== 160) begin errors++; $display("FAIL ignore_ticks got %0d exp 160", tc); end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_extra got %0d active clks exp 0", extra); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    int dones;
    @(negedge clk);
    start[0] = 1'b1;
    data[0]  = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    wait_ticks(88);
    checks++; if (tx_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_bit4 got %b exp 0", tx_w[0]); end
    reset = 1'b1;
    #1;
    checks++; if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_async got tx=%b busy=%b exp tx=1 busy=0", tx_w[0], busy_w[0]);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) dones++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", dones); end
    run_frame(0, 8'h0F, 1, 0, 8'h00, 0, bits, tc, bc, dc, txf, bf);
    checks++; if (bits !== 16'h021E) begin errors++; $display("FAIL midreset_next_bits got %h exp 021e", bits); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL midreset_next_done got %0d exp 1", dc); end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [4];
    logic [15:0] bits;
    int tc, bc, dc;
    logic txf, bf;
    logic [7:0] got;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5; bytes[3] = 8'h3C;
    repeat (800) @(negedge clk);
    rx_q.delete();
    rx_err = 0;
    for (int i = 0; i < 4; i++) begin
      run_frame(0, bytes[i], i == 0, i < 3, (i < 3) ? bytes[(i + 1) % 4] : 8'h00, 0,
                bits, tc, bc, dc, txf, bf);
    end
    repeat (100) @(negedge clk);
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL loop_count got %0d exp 4", rx_q.size()); end
    checks++; if (rx_err !== 0) begin errors++; $display("FAIL loop_framing got %0d errors exp 0", rx_err); end
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== bytes[i]) begin errors++; $display("FAIL loop_byte%0d got %h exp %h", i, got, bytes[i]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_parity;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
